// File: rtl/demux_pkg.sv
// Shared constants and the select-width helper for the 1-to-N stream demux.
package demux_pkg;

  localparam int CNT_W = 16;
  localparam int N_MAX = 16;

  // Select width for n channels, never less than one bit.
  function automatic int sel_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// Single-entry output register for one demux channel.
// DEMUX_1XN_STREAM_CNT_EN adds a wrapping transfer counter.
module demux_chan_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [W-1:0]     din_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic             free_o
`ifdef DEMUX_1XN_STREAM_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A full slot may be refilled in the cycle its consumer drains it.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = din_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef DEMUX_1XN_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && ready_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N valid/ready stream demultiplexer with broadcast and out-of-range drop.
// DEMUX_1XN_STREAM_CNT_EN adds per-channel 16-bit transfer counters (xfer_cnt).
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     din,
  input  logic [SW-1:0]    sel,
  input  logic             bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*W-1:0]   dout,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic             sel_err
`ifdef DEMUX_1XN_STREAM_CNT_EN
  ,
  output logic [N*CNT_W-1:0] xfer_cnt
`endif
);

  localparam int SEL_SPAN = 1 << SW;

  logic [N-1:0]        free;
  logic [N-1:0]        load;
  logic [SEL_SPAN-1:0] free_pad;
  logic                sel_oob;
  logic                accept;
  logic                sel_err_q, sel_err_d;

  assign sel_oob = !bcast && ({1'b0, sel} >= (SW+1)'(N));

  // Unused select codes read as free so out-of-range beats are always taken.
  always_comb begin
    free_pad         = '1;
    free_pad[N-1:0]  = free;
  end

  always_comb begin
    in_ready = 1'b0;
    if (bcast)        in_ready = &free;
    else if (sel_oob) in_ready = 1'b1;
    else              in_ready = free_pad[sel];
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < N; k++) begin
      load[k] = accept && (bcast || (!sel_oob && (sel == SW'(k))));
    end
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_oob) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_chan_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .din_i   (din),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (dout[k*W +: W]),
      .free_o  (free[k])
`ifdef DEMUX_1XN_STREAM_CNT_EN
      ,
      .cnt_o   (xfer_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream (N=4 main instance, N=3 range instance).
module tb_demux_1xn_stream;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    din;
  logic [1:0]    sel;
  logic          bcast, in_valid, in_ready, sel_err;
  logic [31:0]   dout;
  logic [3:0]    out_valid, out_ready;

  logic [7:0]    din3;
  logic [1:0]    sel3;
  logic          bc3, iv3, rdy3, err3;
  logic [23:0]   dout3;
  logic [2:0]    ov3, or3;

`ifdef DEMUX_1XN_STREAM_CNT_EN
  logic [63:0]   xfer_cnt;
  logic [47:0]   cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1xn_stream #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .bcast(bcast),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
`ifdef DEMUX_1XN_STREAM_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  demux_1xn_stream #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel3), .bcast(bc3),
    .in_valid(iv3), .in_ready(rdy3), .dout(dout3),
    .out_valid(ov3), .out_ready(or3), .sel_err(err3)
`ifdef DEMUX_1XN_STREAM_CNT_EN
    , .xfer_cnt(cnt3)
`endif
  );

  task automatic idle_inputs;
    din = '0; sel = '0; bcast = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
    din3 = '0; sel3 = '0; bc3 = 1'b0; iv3 = 1'b0; or3 = 3'b111;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'h0 || dout !== 32'h0 || sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset4: got ov=%b dout=%h err=%b expected 0/0/0", out_valid, dout, sel_err);
    end
    checks++;
    if (ov3 !== 3'b0 || dout3 !== 24'h0 || err3 !== 1'b0) begin
      failures++;
      $display("FAIL reset3: got ov=%b dout=%h err=%b expected 0/0/0", ov3, dout3, err3);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    sel = 2'd2; din = 8'hA5; in_valid = 1'b1; out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL single_rdy: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0100 || dout[23:16] !== 8'hA5) begin
      failures++;
      $display("FAIL single_out: got ov=%b d=%h expected 0100/a5", out_valid, dout[23:16]);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL single_drain: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 4'b1101; sel = 2'd1; din = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h22;
    #1;
    checks++;
    if (out_valid[1] !== 1'b1 || dout[15:8] !== 8'h11 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold: got v=%b d=%h rdy=%b expected 1/11/0", out_valid[1], dout[15:8], in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0010 || dout[15:8] !== 8'h11) begin
      failures++;
      $display("FAIL bp_stable: got ov=%b d=%h expected 0010/11", out_valid, dout[15:8]);
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_refill_rdy: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0010 || dout[15:8] !== 8'h22) begin
      failures++;
      $display("FAIL bp_second: got ov=%b d=%h expected 0010/22", out_valid, dout[15:8]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bcast;
    @(negedge clk);
    out_ready = 4'b1110; sel = 2'd0; din = 8'h77; in_valid = 1'b1; bcast = 1'b0;
    @(posedge clk); #1;
    bcast = 1'b1; din = 8'h3C;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bcast_block: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0001 || dout[7:0] !== 8'h77) begin
      failures++;
      $display("FAIL bcast_wait: got ov=%b d=%h expected 0001/77", out_valid, dout[7:0]);
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bcast_rdy: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; bcast = 1'b0;
    checks++;
    if (out_valid !== 4'b1111 || dout !== 32'h3C3C3C3C) begin
      failures++;
      $display("FAIL bcast_out: got ov=%b d=%h expected 1111/3c3c3c3c", out_valid, dout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_oob_n3;
    @(negedge clk);
    sel3 = 2'd3; din3 = 8'hEE; iv3 = 1'b1; bc3 = 1'b0; or3 = 3'b000;
    #1;
    checks++;
    if (rdy3 !== 1'b1 || err3 !== 1'b0) begin
      failures++; $display("FAIL oob_rdy: got rdy=%b err=%b expected 1/0", rdy3, err3);
    end
    @(posedge clk); #1;
    iv3 = 1'b0;
    checks++;
    if (ov3 !== 3'b000 || err3 !== 1'b1) begin
      failures++; $display("FAIL oob_drop: got ov=%b err=%b expected 000/1", ov3, err3);
    end
    sel3 = 2'd2; iv3 = 1'b1; or3 = 3'b111;
    @(posedge clk); #1;
    iv3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err3 !== 1'b1 || sel_err !== 1'b0) begin
      failures++; $display("FAIL oob_sticky: got err3=%b err4=%b expected 1/0", err3, sel_err);
    end
    do_reset();
    checks++;
    if (err3 !== 1'b0) begin
      failures++; $display("FAIL oob_clear: got %b expected 0", err3);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    out_ready = 4'b0000; bcast = 1'b0; in_valid = 1'b1; sel = 2'd0; din = 8'hA0;
    @(posedge clk); #1;
    sel = 2'd1; din = 8'hA1;
    @(posedge clk); #1;
    sel = 2'd3; din = 8'hA3;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b1011) begin
      failures++; $display("FAIL arst_pre: got %b expected 1011", out_valid);
    end
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || dout !== 32'h0) begin
      failures++; $display("FAIL arst_now: got ov=%b d=%h expected 0/0", out_valid, dout);
    end
    #1;
    rst = 1'b0;
    out_ready = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL arst_after: got %b expected 0000", out_valid);
    end
  endtask

  task automatic test_random;
    logic       mv[N];
    logic [7:0] md[N];
    logic       fr[N];
    logic       all_free, exp_rdy, acc;
    logic [3:0] mvv;
    do_reset();
    for (int k = 0; k < N; k++) begin mv[k] = 1'b0; md[k] = '0; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) mvv[k] = mv[k];
      checks++;
      if (out_valid !== mvv) begin
        failures++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, out_valid, mvv);
      end
      for (int k = 0; k < N; k++) begin
        if (mv[k]) begin
          checks++;
          if (dout[k*W +: W] !== md[k]) begin
            failures++;
            $display("FAIL rand_data c=%0d ch=%0d: got %h expected %h", c, k, dout[k*W +: W], md[k]);
          end
        end
      end
      din       = 8'($urandom);
      sel       = 2'($urandom_range(0, 3));
      bcast     = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 4'($urandom);
      #1;
      all_free = 1'b1;
      for (int k = 0; k < N; k++) begin
        fr[k] = !mv[k] || out_ready[k];
        all_free &= fr[k];
      end
      exp_rdy = bcast ? all_free : fr[sel];
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_rdy c=%0d: got %b expected %b", c, in_ready, exp_rdy);
      end
      acc = in_valid && exp_rdy;
      for (int k = 0; k < N; k++) begin
        if (acc && (bcast || sel == k)) begin
          mv[k] = 1'b1; md[k] = din;
        end else if (out_ready[k]) begin
          mv[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (sel_err !== 1'b0) begin
      failures++; $display("FAIL rand_err: got %b expected 0", sel_err);
    end
  endtask

`ifdef DEMUX_1XN_STREAM_CNT_EN
  task automatic test_counter;
    do_reset();
    out_ready = 4'hF; bcast = 1'b0; sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      din = 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (xfer_cnt[63:48] !== 16'd1 || xfer_cnt[15:0] !== 16'd0) begin
      failures++;
      $display("FAIL cnt_wrap: got ch3=%0d ch0=%0d expected 1/0", xfer_cnt[63:48], xfer_cnt[15:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_bcast();
    test_oob_n3();
    test_async_reset();
    test_random();
`ifdef DEMUX_1XN_STREAM_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
